// File: rtl/circ_pkg.sv
// circ_pkg -- shared types and helpers for the circulant ping-pong transposer.
//
// Holds the FSM state types, the bank-placement function and the sizing
// constants of the default build (N=8, E=2). Other sizes are recomputed
// inside the top module from its own parameters.
package circ_pkg;

   localparam int CIRC_MATRIX_DIM     = 8;
   localparam int CIRC_ELEMS_PER_BEAT = 2;
   localparam int BEATS_PER_ROW       = CIRC_MATRIX_DIM / CIRC_ELEMS_PER_BEAT;
   localparam int ADDR_W              = $clog2(CIRC_MATRIX_DIM);
   localparam int BEAT_CNT_W          = $clog2(CIRC_MATRIX_DIM * BEATS_PER_ROW);

   typedef enum logic {W_FILL, W_WAIT}  wr_state_t;
   typedef enum logic {R_IDLE, R_DRAIN} rd_state_t;

   // Element (row,col) lives in column bank (row+col) mod n, at address row.
   function automatic int circ_bank(input int row, input int col,
                                    input int n = CIRC_MATRIX_DIM);
      return (row + col) & (n - 1);
   endfunction

endpackage

// File: rtl/circ_bank_ram.sv
// circ_bank_ram -- one column bank: DEPTH x ELEM_WIDTH storage with one
// write port and one registered read port (data appears the cycle after re).
//
// Ports:
//   clk    clock
//   we     write enable;  waddr / wdata  write address / data
//   re     read enable;   raddr          read address
//   rdata  registered read data, updated only when re is high
module circ_bank_ram
   import circ_pkg::*;
#(
   parameter int DEPTH      = CIRC_MATRIX_DIM,
   parameter int ADDR_BITS  = ADDR_W,
   parameter int ELEM_WIDTH = 8
) (
   input  logic                  clk,
   input  logic                  we,
   input  logic [ADDR_BITS-1:0]  waddr,
   input  logic [ELEM_WIDTH-1:0] wdata,
   input  logic                  re,
   input  logic [ADDR_BITS-1:0]  raddr,
   output logic [ELEM_WIDTH-1:0] rdata
);

   logic [ELEM_WIDTH-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
      if (re) rdata <= mem[raddr];
   end

endmodule

// File: rtl/circ_transpose_pingpong.sv
// circ_transpose_pingpong -- streaming N x N matrix transposer.
//
// Row-major beats of E elements are written into one of two buffers of N
// circulant column banks (element (r,c) -> bank (r+c) mod N, address r) so
// every beat touches E distinct banks on both the write and the read side.
// While one buffer drains column-major, the other buffer fills.
//
// Ports:
//   clk, rst_n         clock, asynchronous active-low reset
//   s_valid/s_ready    input stream handshake, s_data row-major beat
//   s_last             current write beat is the last beat of a matrix
//   m_valid/m_ready    output stream handshake, m_data column-major beat
//   m_last             final output beat of a matrix
//   buf_full[1:0]      per-buffer "holds a complete matrix" flags
//   transpose_en       only with CIRC_PASSTHRU_EN defined: 0 = read row-major
//
// Optional feature macro: CIRC_PASSTHRU_EN (adds transpose_en).
module circ_transpose_pingpong
   import circ_pkg::*;
#(
   parameter int MATRIX_DIM     = CIRC_MATRIX_DIM,
   parameter int ELEM_WIDTH     = 8,
   parameter int ELEMS_PER_BEAT = CIRC_ELEMS_PER_BEAT,
   parameter int BEAT_WIDTH     = ELEM_WIDTH * ELEMS_PER_BEAT
) (
   input  logic                  clk,
   input  logic                  rst_n,
`ifdef CIRC_PASSTHRU_EN
   input  logic                  transpose_en,
`endif
   input  logic                  s_valid,
   output logic                  s_ready,
   input  logic [BEAT_WIDTH-1:0] s_data,
   output logic                  s_last,
   output logic                  m_valid,
   input  logic                  m_ready,
   output logic [BEAT_WIDTH-1:0] m_data,
   output logic                  m_last,
   output logic [1:0]            buf_full
);

   localparam int  N     = MATRIX_DIM;
   localparam int  E     = ELEMS_PER_BEAT;
   localparam bit  DEF   = (N == CIRC_MATRIX_DIM) && (E == CIRC_ELEMS_PER_BEAT);
   localparam int  B     = DEF ? BEATS_PER_ROW : N / E;
   localparam int  TOTAL = N * B;
   localparam int  AW    = DEF ? ADDR_W : $clog2(N);
   localparam int  CW    = DEF ? BEAT_CNT_W : $clog2(TOTAL);

   wr_state_t       wr_state, wr_state_nxt;
   rd_state_t       rd_state, rd_state_nxt;
   logic            wr_ptr, rd_ptr;
   logic [CW-1:0]   wr_cnt, rd_cnt;
   logic            wr_fire, wr_done, rd_issue, rd_done, tr_mode;

   logic                  wr_en_b   [N];
   logic [ELEM_WIDTH-1:0] wr_dat_b  [N];
   logic [AW-1:0]         wr_addr;
   logic [AW-1:0]         rd_addr_b [N];
   logic [AW-1:0]         rd_sel    [E];
   logic [ELEM_WIDTH-1:0] bank_rdata [2][N];

   logic                  vld_p1, buf_p1, last_p1;
   logic [AW-1:0]         sel_p1 [E];
   logic [BEAT_WIDTH-1:0] data_p1;

   logic [BEAT_WIDTH-1:0] fifo_dat [2];
   logic                  fifo_lst [2];
   logic [1:0]            fifo_cnt;
   logic                  fifo_wi, fifo_ri;
   logic                  pop, push, pop_fifo, room;

   // ---------------- write FSM ----------------
   always_comb begin
      wr_state_nxt = wr_state;
      s_ready      = 1'b0;
      wr_done      = 1'b0;
      case (wr_state)
         W_FILL: begin
            s_ready = 1'b1;
            if (s_valid && wr_cnt == CW'(TOTAL - 1)) begin
               wr_done = 1'b1;
               // A buffer freed by the reader this very cycle counts as free.
               if (buf_full[~wr_ptr] && !(rd_done && rd_ptr == ~wr_ptr))
                  wr_state_nxt = W_WAIT;
            end
         end
         W_WAIT: if (!buf_full[wr_ptr]) wr_state_nxt = W_FILL;
         default: wr_state_nxt = W_FILL;
      endcase
   end

   assign wr_fire = s_valid && s_ready;
   assign s_last  = (wr_state == W_FILL) && (wr_cnt == CW'(TOTAL - 1));

   // Steer each element of the incoming beat to its circulant bank.
   always_comb begin
      int row, beat, bank;
      for (int j = 0; j < N; j++) begin
         wr_en_b[j]  = 1'b0;
         wr_dat_b[j] = '0;
      end
      row     = int'(wr_cnt) / B;
      beat    = int'(wr_cnt) % B;
      wr_addr = AW'(row);
      for (int k = 0; k < E; k++) begin
         bank           = circ_bank(row, beat * E + k, N);
         wr_en_b[bank]  = wr_fire;
         wr_dat_b[bank] = s_data[k*ELEM_WIDTH +: ELEM_WIDTH];
      end
   end

   // ---------------- read FSM ----------------
   // room: the beat issued now still has a skid slot when it lands next cycle.
   assign m_valid  = (fifo_cnt != 2'd0) || vld_p1;
   assign pop      = m_valid && m_ready;
   assign pop_fifo = pop && (fifo_cnt != 2'd0);
   assign push     = vld_p1 && !((fifo_cnt == 2'd0) && m_ready);

   always_comb begin
      int occ;
      occ  = int'(fifo_cnt) + int'(vld_p1) - int'(pop);
      room = (occ < 2);
   end

   always_comb begin
      rd_state_nxt = rd_state;
      rd_issue     = 1'b0;
      rd_done      = 1'b0;
      case (rd_state)
         R_IDLE:  if (buf_full[rd_ptr]) rd_state_nxt = R_DRAIN;
         R_DRAIN: if (room) begin
            rd_issue = 1'b1;
            if (rd_cnt == CW'(TOTAL - 1)) begin
               rd_done      = 1'b1;
               rd_state_nxt = R_IDLE;
            end
         end
         default: rd_state_nxt = R_IDLE;
      endcase
   end

   // Per output element k: transposed reads row base+k of column major;
   // passthrough reads column base+k of row major.
   always_comb begin
      int major, base, row, col, bank;
      for (int j = 0; j < N; j++) rd_addr_b[j] = '0;
      for (int k = 0; k < E; k++) rd_sel[k] = '0;
      major = int'(rd_cnt) / B;
      base  = (int'(rd_cnt) % B) * E;
      for (int k = 0; k < E; k++) begin
         if (tr_mode) begin
            row = base + k;
            col = major;
         end else begin
            row = major;
            col = base + k;
         end
         bank            = circ_bank(row, col, N);
         rd_addr_b[bank] = AW'(row);
         rd_sel[k]       = AW'(bank);
      end
   end

   // ---------------- storage: 2 buffers x N banks ----------------
   for (genvar p = 0; p < 2; p++) begin : g_buf
      for (genvar j = 0; j < N; j++) begin : g_bank
         circ_bank_ram #(
            .DEPTH      (N),
            .ADDR_BITS  (AW),
            .ELEM_WIDTH (ELEM_WIDTH)
         ) u_bank (
            .clk   (clk),
            .we    (wr_en_b[j] && (wr_ptr == 1'(p))),
            .waddr (wr_addr),
            .wdata (wr_dat_b[j]),
            .re    (rd_issue && (rd_ptr == 1'(p))),
            .raddr (rd_addr_b[j]),
            .rdata (bank_rdata[p][j])
         );
      end
   end

   // ---------------- control registers ----------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_state <= W_FILL;
         rd_state <= R_IDLE;
         wr_ptr   <= 1'b0;
         rd_ptr   <= 1'b0;
         wr_cnt   <= '0;
         rd_cnt   <= '0;
         buf_full <= 2'b00;
         vld_p1   <= 1'b0;
         fifo_cnt <= 2'd0;
         fifo_wi  <= 1'b0;
         fifo_ri  <= 1'b0;
      end else begin
         wr_state <= wr_state_nxt;
         rd_state <= rd_state_nxt;
         if (wr_fire)  wr_cnt <= wr_cnt + CW'(1);
         if (wr_done)  wr_ptr <= ~wr_ptr;
         if (rd_issue) rd_cnt <= rd_cnt + CW'(1);
         if (rd_done)  rd_ptr <= ~rd_ptr;
         // Writer and reader always own different buffers, so both may update.
         if (wr_done)  buf_full[wr_ptr] <= 1'b1;
         if (rd_done)  buf_full[rd_ptr] <= 1'b0;
         vld_p1   <= rd_issue;
         fifo_cnt <= fifo_cnt + {1'b0, push} - {1'b0, pop_fifo};
         if (push)     fifo_wi <= ~fifo_wi;
         if (pop_fifo) fifo_ri <= ~fifo_ri;
      end
   end

`ifdef CIRC_PASSTHRU_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                                 tr_mode <= 1'b1;
      else if (rd_state == R_IDLE && buf_full[rd_ptr]) tr_mode <= transpose_en;
   end
`else
   assign tr_mode = 1'b1;
`endif

   // ---------------- p1: bank read data lands ----------------
   always_ff @(posedge clk) begin
      if (rd_issue) begin
         buf_p1  <= rd_ptr;
         sel_p1  <= rd_sel;
         last_p1 <= rd_done;
      end
      if (push) begin
         fifo_dat[fifo_wi] <= data_p1;
         fifo_lst[fifo_wi] <= last_p1;
      end
   end

   always_comb begin
      data_p1 = '0;
      for (int k = 0; k < E; k++)
         data_p1[k*ELEM_WIDTH +: ELEM_WIDTH] = bank_rdata[buf_p1][sel_p1[k]];
   end

   // ---------------- output: skid head or bypassed landing beat ----------------
   always_comb begin
      m_data = '0;
      m_last = 1'b0;
      if (fifo_cnt != 2'd0) begin
         m_data = fifo_dat[fifo_ri];
         m_last = fifo_lst[fifo_ri];
      end else if (vld_p1) begin
         m_data = data_p1;
         m_last = last_p1;
      end
   end

endmodule
